alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 8-bit combinational ALU. It adds a
//  valid/ready handshake on input and output, an architectural carry register
//  for ADC/SBB chaining, and an iterative multi-cycle multiply. It sits between
//  the operand/opcode issuer and any consumer that may stall.
// PARAMETERS
//  WIDTH     8   operand/result width in bits (>=4)
//  MUL_EN    1   1: MUL implemented; 0: MUL treated as reserved opcode
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      opcode/a/b valid
//  in_ready   out  1      block can accept; transfer = in_valid & in_ready
//  opcode     in   4      operation select (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts; transfer = out_valid & out_ready
//  result     out  WIDTH  registered result
//  carry      out  1      carry/borrow flag of the presented result
//  s          out  1      sign = result[WIDTH-1]
//  z          out  1      1 when result == 0
//  p          out  1      even parity: 1 when result has an even count of ones
//  v          out  1      signed overflow (add/sub class only, else 0)
//  busy       out  1      MUL in progress
// BEHAVIOUR
//  Reset (async): out_valid=0, result=0, carry=0, s=0, z=0, p=0, v=0, busy=0,
//   carry_q=0, MUL FSM=IDLE. in_ready=0 while rst is high.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical),
//   8 INC A, 9 DEC A, 10 ADC (A+B+carry_q), 11 SBB (A-B-carry_q), 12 MUL,
//   13-15 reserved: result=A, carry unchanged, v=0.
//  Arithmetic is at WIDTH+1 bits; result = low WIDTH bits.
//   Add class: carry = bit WIDTH. Sub class: carry = borrow (1 when A < B+cin).
//   SHL: carry=A[WIDTH-1]. SHR: carry=A[0]. Logic ops: carry=0.
//   MUL: result = low WIDTH bits of the 2*WIDTH product, carry = |high half, v=0.
//  carry_q updates with the flags every time a result loads into the output register.
//  in_ready = ~busy & (~out_valid | out_ready).
//  Single-cycle ops: the op accepted at edge N is presented at edge N (out_valid high
//   during cycle N+1), giving 1-cycle latency. Throughput is 1/cycle when out_ready=1.
//  MUL FSM: IDLE -(accept op 12)-> RUN (busy=1, shift-add over WIDTH cycles,
//   in_ready=0) -> LOAD (result written, busy=0) -> IDLE. out_valid rises exactly
//   WIDTH cycles after the accept edge. RUN never starts while out_valid & ~out_ready.
//  Output holding: while out_valid & ~out_ready, result and flags stay stable.
//  Simultaneous output accept and input accept: the old result retires and the new one
//   loads on the same edge, with no bubble.
//  rst during RUN: the multiply is aborted, no output is produced, and state is as at reset.
//  A/B/opcode are sampled only on an input transfer; changes at other times are ignored.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_SBB, OP_MUL), MUL FSM state encodings.
//  Sub-module alu_mul_seq: start/a/b in, done/product[2*WIDTH-1:0] out, WIDTH cycles.
//  Top level: the combinational op decode, the flag logic, carry_q, and the output register.
// TESTING (WIDTH=8)
//  1 ADD a=9A b=AA -> result 44, carry=1, v=1, s=0, z=0, p=1; out_valid 1 cycle after accept.
//  2 Follow with ADC a=00 b=00 -> result 01, carry=0, p=0; then SUB a=0B b=54 ->
//    result B7, carry=1, s=1, v=0, p=1.
//  3 MUL a=FF b=15 -> result EB, carry=1; busy=1 and in_ready=0 for 8 cycles; out_valid at
//    accept+8.
//  4 Backpressure: out_ready=0, issue AND F0,3C then OR 01,02 -> result 30 held stable,
//    in_ready=0; raise out_ready -> 30 retires, then 03 appears next cycle.
//  5 Back-to-back streaming of 16 ops with out_ready=1 -> one result per cycle, in order,
//    no bubbles.
//  6 Assert rst 3 cycles into MUL -> out_valid=0, carry=0, busy=0 immediately; after release,
//    ADD 01,01 -> result 02, carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and multiply-sequencer state type for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_SBB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: the first partial product is taken on the start
// edge, so the full product is ready (done=1) WIDTH-1 cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic               r_act;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_mplr  <= '0;
    end else if (i_start) begin
      r_act   <= 1'b1;
      r_cnt   <= CW'(WIDTH - 1);
      r_prod  <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
      r_mcand <= {{WIDTH{1'b0}}, i_a} << 1;
      r_mplr  <= i_b >> 1;
    end else if (r_act) begin
      if (r_cnt != '0) begin
        r_prod  <= r_prod + (r_mplr[0] ? r_mcand : '0);
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt - 1'b1;
      end else begin
        r_act <= 1'b0;
      end
    end
  end

  assign o_done    = r_act & (r_cnt == '0);
  assign o_product = r_prod;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides, carry chaining for ADC/SBB and a
// multi-cycle multiply. Single-cycle ops load the output register on the accept edge.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             s,
  output logic             z,
  output logic             p,
  output logic             v,
  output logic             busy
);

  localparam bit HAS_MUL = (MUL_EN != 0);

  mul_state_e         r_state, w_state_nxt;
  logic               r_out_valid, r_carry, r_s, r_z, r_p, r_v;
  logic [WIDTH-1:0]   r_result;

  logic               w_fire, w_is_mul, w_mul_fire, w_single_fire, w_load;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_res, w_opb, w_res_n;
  logic [WIDTH:0]     w_sum;
  logic               w_c, w_v, w_cin, w_c_n, w_v_n;

  assign busy          = (r_state == S_RUN);
  assign in_ready      = ~rst & ~busy & (~r_out_valid | out_ready);
  assign w_fire        = in_valid & in_ready;
  assign w_is_mul      = HAS_MUL && (opcode == OP_MUL);
  assign w_mul_fire    = w_fire & w_is_mul;
  assign w_single_fire = w_fire & ~w_is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_fire),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // LOAD is the cycle the product is presented; it accepts like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_LOAD: w_state_nxt = w_mul_fire ? S_RUN : S_IDLE;
      S_RUN:          if (w_mul_done) w_state_nxt = S_LOAD;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_res = a;
    w_c   = r_carry;
    w_v   = 1'b0;
    w_opb = b;
    w_cin = 1'b0;
    w_sum = '0;
    case (opcode)
      OP_ADD, OP_INC, OP_ADC: begin
        if (opcode == OP_INC) w_opb = WIDTH'(1);
        if (opcode == OP_ADC) w_cin = r_carry;
        w_sum = {1'b0, a} + {1'b0, w_opb} + (WIDTH+1)'(w_cin);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == w_opb[WIDTH-1]) & (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC, OP_SBB: begin
        if (opcode == OP_DEC) w_opb = WIDTH'(1);
        if (opcode == OP_SBB) w_cin = r_carry;
        // Bit WIDTH of the extended difference is the borrow.
        w_sum = {1'b0, a} - {1'b0, w_opb} - (WIDTH+1)'(w_cin);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] != w_opb[WIDTH-1]) & (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin w_res = a & b; w_c = 1'b0; end
      OP_OR:  begin w_res = a | b; w_c = 1'b0; end
      OP_XOR: begin w_res = a ^ b; w_c = 1'b0; end
      OP_NOT: begin w_res = ~a;    w_c = 1'b0; end
      OP_SHL: begin w_res = a << 1; w_c = a[WIDTH-1]; end
      OP_SHR: begin w_res = a >> 1; w_c = a[0]; end
      default: ;
    endcase
  end

  assign w_load  = w_single_fire | w_mul_done;
  assign w_res_n = w_mul_done ? w_product[WIDTH-1:0] : w_res;
  assign w_c_n   = w_mul_done ? |w_product[2*WIDTH-1:WIDTH] : w_c;
  assign w_v_n   = w_mul_done ? 1'b0 : w_v;

  // r_carry doubles as the chaining carry for ADC/SBB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_s         <= 1'b0;
      r_z         <= 1'b0;
      r_p         <= 1'b0;
      r_v         <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res_n;
      r_carry     <= w_c_n;
      r_s         <= w_res_n[WIDTH-1];
      r_z         <= (w_res_n == '0);
      r_p         <= ~^w_res_n;
      r_v         <= w_v_n;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign s         = r_s;
  assign z         = r_z;
  assign p         = r_p;
  assign v         = r_v;

endmodule
